jt7759_rom_bridge: RTL and testbench
====================================

// Module: jt7759_rom_bridge
// PURPOSE
//  ROM responder for the jt7759 control FSM: answers its byte requests (rom_cs/rom_addr -> rom_data/rom_ok)
//  from a 16-bit request/acknowledge memory bus (SDRAM controller port). Holds one cached line of
//  2**LW 16-bit words so sequential ADPCM/header reads hit without a memory round trip.
//  Sits between jt7759 and the system memory arbiter; one instance per jt7759.
// PARAMETERS
//  AW      22      memory word-address width
//  OFFSET  0       word address of ROM byte 0 in memory (AW bits)
//  LW      1       log2 of words per line; line = 2**(LW+1) bytes (default 4 bytes)
// PORTS
//  clk       in   1    system clock, single clock domain
//  rstn      in   1    asynchronous, active-low reset
//  inval     in   1    one-cycle pulse: invalidate line (after ROM download)
//  rom_cs    in   1    byte request from jt7759
//  rom_addr  in   17   byte address from jt7759
//  rom_data  out  8    requested byte
//  rom_ok    out  1    rom_data valid for rom_addr of previous cycle
//  mem_req   out  1    memory request, held until mem_ack
//  mem_addr  out  AW   memory word address, stable while mem_req high
//  mem_ack   in   1    one-cycle pulse: mem_dout valid, request done
//  mem_dout  in   16   memory word; byte 2k in [7:0], byte 2k+1 in [15:8]
// BEHAVIOUR
//  Reset: rom_ok=0, rom_data=0, mem_req=0, mem_addr=0, line valid=0, tag=0, FSM=IDLE.
//  Hit = valid && tag==rom_addr[16:LW+1]. rom_ok and rom_data are registered:
//   rom_ok <= rom_cs && hit && FSM==IDLE; rom_data <= line byte rom_addr[LW:0] (updated on hit only).
//   -> address change at edge N gives rom_ok for new address no earlier than edge N+1; a stale rom_ok
//      is never presented in the cycle after the change (jt7759 samples one cycle after changing addr).
//  rom_cs low -> rom_ok 0 next cycle; rom_data holds.
//  FSM (one-hot, 3 states):
//   IDLE : rom_cs && !hit -> latch tag=rom_addr[16:LW+1], valid=0, wcnt=0, mem_req=1,
//          mem_addr=OFFSET+{tag,wcnt}; go FETCH.
//   FETCH: on mem_ack store mem_dout in word wcnt; if wcnt==all ones -> mem_req=0, go FILL;
//          else wcnt+1, mem_addr+1, mem_req stays 1 (no idle gap between words).
//   FILL : valid=1; go IDLE (rom_ok rises no earlier than the next cycle via the hit path).
//  mem_addr sum wraps modulo 2**AW; no overflow flag.
//  Miss-to-ok latency: req issue 1 cycle after miss seen; rom_ok 2 cycles after final mem_ack.
//  rom_addr change or rom_cs drop mid-FETCH: handshake never aborted; line completes with the
//   latched tag, then IDLE re-evaluates hit against current address (may refetch).
//  inval: clears valid in any state; mid-FETCH the fetch completes but FILL leaves valid=0
//   (inval_pend flag), so a request after inval always refetches. inval and FILL same cycle: inval wins.
//  mem_ack while mem_req low: ignored.
// STRUCTURE
//  Shared package jt7759_pkg: ROM address width 17, state encodings, byte-lane order constant.
//  Sub-module jt7759_rom_line: line storage (2**LW x 16 regs), word write port, byte read mux.
//  Top holds FSM, tag/valid, handshake and output registers.
// TESTING
//  T1 reset then rom_cs=1 addr=0, memory word0=A55A, word1=5569 -> one 2-word fetch at OFFSET,
//     rom_ok rises 2 clk after 2nd ack, data 5A; addr 1,2,3 -> A5,69,55 with no new mem_req.
//  T2 addr 3 -> 4 (line cross): rom_ok low cycle after change, mem_addr=OFFSET+2, data valid after fill.
//  T3 OFFSET=22'h10000, addr 17'h1FFFF -> mem_addr 22'h1FFFE..1FFFF, rom_data = high byte of word 1.
//  T4 change addr to other line mid-FETCH with ack delayed 5 clk: first line fills, then refetch;
//     rom_ok never high for wrong byte (scoreboard vs memory model).
//  T5 inval pulse during FETCH -> line completes, next request to same addr refetches (mem_req seen).
//  T6 rstn low mid-FETCH -> all outputs 0 asynchronously; after release clean miss on first request.

Source files
------------

// File: rtl/jt7759_pkg.sv
// Shared definitions for the jt7759 ROM bridge: address width, FSM encoding, byte-lane order.
package jt7759_pkg;

    localparam int ROM_AW = 17;

    // Even ROM byte lives in mem_dout[7:0], odd byte in [15:8]
    localparam logic LO_BYTE_FIRST = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_FETCH = 3'b010,
        ST_FILL  = 3'b100
    } state_t;

endpackage

// File: rtl/jt7759_rom_line.sv
// One cached line of 2**LW 16-bit words: word write port and combinational byte read mux.
module jt7759_rom_line
    import jt7759_pkg::*;
#(
    parameter int LW = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          we,
    input  logic [LW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [LW:0]   raddr,
    output logic [7:0]    rdata
);

    localparam int WORDS = 2**LW;

    logic [WORDS-1:0][15:0] words;
    logic [15:0]            rword;
    logic                   sel_hi;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)   words        <= '0;
        else if (we) words[waddr] <= wdata;
    end

    assign rword  = words[raddr[LW:1]];
    assign sel_hi = (raddr[0] == LO_BYTE_FIRST);
    assign rdata  = sel_hi ? rword[15:8] : rword[7:0];

endmodule

// File: rtl/jt7759_rom_bridge.sv
// Byte ROM responder for jt7759 backed by a 16-bit req/ack memory port with a one-line cache.
module jt7759_rom_bridge
    import jt7759_pkg::*;
#(
    parameter int            AW     = 22,
    parameter logic [AW-1:0] OFFSET = '0,
    parameter int            LW     = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              inval,
    input  logic              rom_cs,
    input  logic [ROM_AW-1:0] rom_addr,
    output logic [7:0]        rom_data,
    output logic              rom_ok,
    output logic              mem_req,
    output logic [AW-1:0]     mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_dout
);

    localparam int TW = ROM_AW - LW - 1;

    state_t        state, state_nxt;
    logic [TW-1:0] tag, req_tag;
    logic [LW-1:0] wcnt;
    logic          valid, inval_pend;
    logic          hit, ack, last, start, serve;
    logic [7:0]    line_byte;

    assign req_tag = rom_addr[ROM_AW-1:LW+1];
    assign hit     = valid && (tag == req_tag);
    assign ack     = mem_req && mem_ack;
    assign last    = &wcnt;
    assign serve   = rom_cs && hit && (state == ST_IDLE);

    jt7759_rom_line #(.LW(LW)) u_line (
        .clk   (clk),
        .rstn  (rstn),
        .we    (ack),
        .waddr (wcnt),
        .wdata (mem_dout),
        .raddr (rom_addr[LW:0]),
        .rdata (line_byte)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rom_cs && !hit) begin
                    start     = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: if (ack && last) state_nxt = ST_FILL;
            ST_FILL:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rom_ok     <= 1'b0;
            rom_data   <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            tag        <= '0;
            wcnt       <= '0;
            valid      <= 1'b0;
            inval_pend <= 1'b0;
        end else begin
            // Registered hit path: a fresh address can never see last cycle's rom_ok
            rom_ok <= serve;
            if (serve) rom_data <= line_byte;

            if (start) begin
                tag      <= req_tag;
                wcnt     <= '0;
                mem_req  <= 1'b1;
                mem_addr <= OFFSET + AW'({req_tag, {LW{1'b0}}});
            end else if (ack) begin
                if (last) begin
                    mem_req <= 1'b0;
                end else begin
                    wcnt     <= wcnt + LW'(1);
                    mem_addr <= mem_addr + AW'(1);
                end
            end

            // A fetch already in flight when inval arrives may hold pre-download data
            if (inval)                     valid <= 1'b0;
            else if (start)                valid <= 1'b0;
            else if (state == ST_FILL)     valid <= !inval_pend;

            if (inval && state == ST_FETCH) inval_pend <= 1'b1;
            else if (state == ST_FILL)      inval_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jt7759_rom_bridge.sv
// Scoreboard bench for jt7759_rom_bridge: memory responder model, queued expectations, negedge monitor.
module tb_jt7759_rom_bridge;

    localparam int         AW     = 22;
    localparam logic [21:0] OFFSET = 22'h10000;

    logic        clk = 1'b0, rstn = 1'b0, inval = 1'b0, rom_cs = 1'b0;
    logic [16:0] rom_addr = '0;
    logic [7:0]  rom_data;
    logic        rom_ok, mem_req;
    logic [21:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_dout = '0;

    always #5 clk = ~clk;

    jt7759_rom_bridge #(.AW(AW), .OFFSET(OFFSET), .LW(1)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .inval    (inval),
        .rom_cs   (rom_cs),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rom_ok   (rom_ok),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_dout (mem_dout)
    );

    int n_chk = 0, n_fail = 0, cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [21:0] a);
        if (a == OFFSET)         return 16'hA55A;
        if (a == OFFSET + 22'd1) return 16'h5569;
        return {a[7:0] ^ 8'hC3, a[15:8] + a[7:0] + 8'h11};
    endfunction

    function automatic logic [7:0] byte_of(input logic [16:0] ra);
        logic [21:0] wa;
        logic [15:0] w;
        wa = OFFSET + {6'b0, ra[16:1]};
        w  = mem_word(wa);
        return ra[0] ? w[15:8] : w[7:0];
    endfunction

    // Memory responder: acks each word ack_dly cycles after it becomes pending
    int          ack_dly = 1, wait_r = 0, fetch_cnt = 0, last_ack_cyc = 0;
    logic [21:0] mlog[$];
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (mem_req) begin
            if (wait_r >= ack_dly) begin
                mem_ack  = 1'b1;
                mem_dout = mem_word(mem_addr);
                wait_r   = 0;
                fetch_cnt++;
                last_ack_cyc = cyc;
                mlog.push_back(mem_addr);
            end else begin
                wait_r++;
            end
        end else begin
            wait_r = 0;
        end
    end

    typedef struct { logic [16:0] addr; logic [7:0] data; } exp_t;
    exp_t sb[$];
    int   done_cnt = 0, want = 0, ok_rise_cyc = 0;
    logic [16:0] samp_addr = '0;
    logic        samp_cs = 1'b0, prev_ok = 1'b0;

    always @(posedge clk) begin
        samp_addr = rom_addr;
        samp_cs   = rom_cs;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rom_ok) begin
            if (!prev_ok) ok_rise_cyc = cyc;
            check("ok_needs_cs", {31'b0, samp_cs}, 32'd1);
            if (sb.size() > 0 && sb[0].addr == samp_addr) begin
                e = sb.pop_front();
                check("sb_data", {24'b0, rom_data}, {24'b0, e.data});
                done_cnt++;
            end else begin
                check("held_data", {24'b0, rom_data}, {24'b0, byte_of(samp_addr)});
            end
        end
        prev_ok = rom_ok;
    end

    task automatic issue(input logic [16:0] a, input logic [7:0] d);
        rom_addr = a;
        rom_cs   = 1'b1;
        sb.push_back('{a, d});
        want++;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_cnt < want && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt < want) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: timeout, done %0d required %0d", name, done_cnt, want);
            sb.delete();
            done_cnt = want;
        end
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!mem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'b0, mem_req}, 32'd1);
    endtask

    task automatic drop_cs(input string name);
        rom_cs = 1'b0;
        @(negedge clk);
        check(name, {31'b0, rom_ok}, 32'd0);
    endtask

    task automatic rd(input logic [16:0] a, input logic [7:0] d, input string name);
        issue(a, d);
        wait_done(name);
        drop_cs({name, "_csdrop"});
    endtask

    int f0;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ok",    {31'b0, rom_ok},  0);
        check("rst_data",  {24'b0, rom_data}, 0);
        check("rst_req",   {31'b0, mem_req}, 0);
        check("rst_maddr", {10'b0, mem_addr}, 0);
        rstn = 1'b1;
        @(negedge clk);

        // T1: first miss fetches two words, then the whole line hits
        ack_dly = 1; mlog.delete(); f0 = fetch_cnt;
        rd(17'd0, 8'h5A, "t1_b0");
        check("t1_fetches", fetch_cnt - f0, 2);
        check("t1_addr0", {10'b0, mlog[0]}, {10'b0, OFFSET});
        check("t1_addr1", {10'b0, mlog[1]}, {10'b0, OFFSET + 22'd1});
        check("t1_latency", ok_rise_cyc - last_ack_cyc, 3);
        rd(17'd1, 8'hA5, "t1_b1");
        rd(17'd2, 8'h69, "t1_b2");
        issue(17'd3, 8'h55);
        wait_done("t1_b3");
        check("t1_nofetch", fetch_cnt - f0, 2);

        // T2: line cross with rom_cs held high
        issue(17'd4, byte_of(17'd4));
        @(negedge clk);
        check("t2_ok_low", {31'b0, rom_ok}, 0);
        check("t2_req",    {31'b0, mem_req}, 1);
        check("t2_maddr",  {10'b0, mem_addr}, {10'b0, OFFSET + 22'd2});
        wait_done("t2_b4");
        drop_cs("t2_csdrop");

        // T3: top of ROM space
        mlog.delete();
        rd(17'h1FFFF, mem_word(22'h1FFFF) >> 8, "t3_top");
        check("t3_addr0", {10'b0, mlog[0]}, 32'h1FFFE);
        check("t3_addr1", {10'b0, mlog[1]}, 32'h1FFFF);

        // T4: address moves to another line mid-fetch
        ack_dly = 5; mlog.delete(); f0 = fetch_cnt;
        rom_addr = 17'd8; rom_cs = 1'b1;
        wait_req("t4_req");
        repeat (2) @(negedge clk);
        issue(17'd20, byte_of(17'd20));
        wait_done("t4_b20");
        drop_cs("t4_csdrop");
        check("t4_fetches", fetch_cnt - f0, 4);
        check("t4_addr0", {10'b0, mlog[0]}, {10'b0, OFFSET + 22'd4});
        check("t4_addr2", {10'b0, mlog[2]}, {10'b0, OFFSET + 22'd10});

        // T5: inval during fetch forces a refetch; inval while idle too
        ack_dly = 3; f0 = fetch_cnt;
        issue(17'd40, byte_of(17'd40));
        wait_req("t5_req");
        inval = 1'b1;
        @(negedge clk);
        inval = 1'b0;
        wait_done("t5_b40");
        drop_cs("t5_csdrop");
        check("t5_refetch", fetch_cnt - f0, 4);
        f0 = fetch_cnt;
        rd(17'd41, byte_of(17'd41), "t5_b41");
        check("t5_hit", fetch_cnt - f0, 0);
        inval = 1'b1;
        @(negedge clk);
        inval = 1'b0;
        rd(17'd41, byte_of(17'd41), "t5_b41i");
        check("t5_idle_inval", fetch_cnt - f0, 2);

        // T6: asynchronous reset in the middle of a fetch
        ack_dly = 4;
        rom_addr = 17'h100; rom_cs = 1'b1;
        wait_req("t6_req");
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("t6_ok",    {31'b0, rom_ok},  0);
        check("t6_data",  {24'b0, rom_data}, 0);
        check("t6_req0",  {31'b0, mem_req}, 0);
        check("t6_maddr", {10'b0, mem_addr}, 0);
        rom_cs = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        f0 = fetch_cnt; mlog.delete();
        rd(17'h100, byte_of(17'h100), "t6_b100");
        check("t6_fetches", fetch_cnt - f0, 2);
        check("t6_addr0", {10'b0, mlog[0]}, {10'b0, OFFSET + 22'h80});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
